// File: rtl/keypad_decoder.sv
// keypad_decoder
//   Decodes a 4x4 matrix keypad scanned by an external row scanner.
//   A press announced by `change` is captured (rows/cols each one-hot),
//   then it must persist unchanged for CONFIRM_CYCLES consecutive cycles
//   before it is accepted. While the key is held no further key is
//   reported. Release requires RELEASE_CYCLES consecutive cycles of cols==0.
//
// Parameters
//   CONFIRM_CYCLES : cycles a captured pattern must persist (1..63)
//   RELEASE_CYCLES : consecutive cols==0 cycles that declare release (1..63)
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-low reset
//   rows[3:0]  in   row drive from scanner, active-high
//   cols[3:0]  in   column sense from keypad, active-high
//   change     in   one-cycle strobe marking a new press
//   key_valid  out  one-cycle pulse when a key is accepted
//   key[3:0]   out  hex code of last accepted key
//   digit_new  out  most recent accepted key
//   digit_old  out  previously accepted key
//   err        out  one-cycle pulse after a change with an invalid pattern
//
// Build option
//   KEYPAD_DECODER_ERR_EN : when defined, err is driven; otherwise err is 0.

module keypad_decoder #(
  parameter int unsigned CONFIRM_CYCLES = 4,
  parameter int unsigned RELEASE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  input  logic [3:0] cols,
  input  logic       change,
  output logic       key_valid,
  output logic [3:0] key,
  output logic [3:0] digit_new,
  output logic [3:0] digit_old,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, CONFIRM, HOLD} state_t;

  localparam logic [5:0] CONF_LIM = 6'(CONFIRM_CYCLES);
  localparam logic [5:0] REL_LIM  = 6'(RELEASE_CYCLES);

  state_t     state_q, state_d;
  logic [3:0] rows_q, rows_d;
  logic [3:0] cols_q, cols_d;
  logic [5:0] cnt_q, cnt_d;
  logic [5:0] rel_q, rel_d;
  logic       key_valid_q, key_valid_d;
  logic [3:0] key_q, key_d;
  logic [3:0] digit_new_q, digit_new_d;
  logic [3:0] digit_old_q, digit_old_d;

  logic [5:0] cnt_inc;
  logic [5:0] rel_inc;
  logic       pattern_ok;
  logic [3:0] decoded;

  // Captured row/col are one-hot; fold them to 2-bit indices for the table.
  function automatic logic [3:0] decode(input logic [3:0] r, input logic [3:0] c);
    logic [1:0] ri;
    logic [1:0] ci;
    ri = {r[3] | r[2], r[3] | r[1]};
    ci = {c[3] | c[2], c[3] | c[1]};
    case ({ri, ci})
      4'h0: decode = 4'h1;  4'h1: decode = 4'h2;  4'h2: decode = 4'h3;  4'h3: decode = 4'hA;
      4'h4: decode = 4'h4;  4'h5: decode = 4'h5;  4'h6: decode = 4'h6;  4'h7: decode = 4'hB;
      4'h8: decode = 4'h7;  4'h9: decode = 4'h8;  4'hA: decode = 4'h9;  4'hB: decode = 4'hC;
      4'hC: decode = 4'hE;  4'hD: decode = 4'h0;  4'hE: decode = 4'hF;  default: decode = 4'hD;
    endcase
  endfunction

  always_comb begin
    cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + 6'd1;
    rel_inc    = (rel_q == '1) ? rel_q : rel_q + 6'd1;
    pattern_ok = $onehot(rows) && $onehot(cols);
    decoded    = decode(rows_q, cols_q);

    state_d     = state_q;
    rows_d      = rows_q;
    cols_d      = cols_q;
    cnt_d       = cnt_q;
    rel_d       = rel_q;
    key_valid_d = 1'b0;
    key_d       = key_q;
    digit_new_d = digit_new_q;
    digit_old_d = digit_old_q;

    case (state_q)
      IDLE: begin
        if (change && pattern_ok) begin
          rows_d  = rows;
          cols_d  = cols;
          cnt_d   = '0;
          state_d = CONFIRM;
        end
      end
      CONFIRM: begin
        if (rows == rows_q && cols == cols_q) begin
          cnt_d = cnt_inc;
          if (cnt_inc >= CONF_LIM) begin
            key_valid_d = 1'b1;
            key_d       = decoded;
            digit_new_d = decoded;
            digit_old_d = digit_new_q;
            rel_d       = '0;
            state_d     = HOLD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        // change is deliberately not examined here, including the exit cycle.
        if (cols == 4'b0000) begin
          rel_d = rel_inc;
          if (rel_inc >= REL_LIM) state_d = IDLE;
        end else begin
          rel_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      rows_q      <= '0;
      cols_q      <= '0;
      cnt_q       <= '0;
      rel_q       <= '0;
      key_valid_q <= 1'b0;
      key_q       <= '0;
      digit_new_q <= '0;
      digit_old_q <= '0;
    end else begin
      state_q     <= state_d;
      rows_q      <= rows_d;
      cols_q      <= cols_d;
      cnt_q       <= cnt_d;
      rel_q       <= rel_d;
      key_valid_q <= key_valid_d;
      key_q       <= key_d;
      digit_new_q <= digit_new_d;
      digit_old_q <= digit_old_d;
    end
  end

`ifdef KEYPAD_DECODER_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = (state_q == IDLE) && change && !pattern_ok;
  end

  always_ff @(posedge clk) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign key_valid = key_valid_q;
  assign key       = key_q;
  assign digit_new = digit_new_q;
  assign digit_old = digit_old_q;

endmodule

// File: tb/tb_keypad_decoder.sv
// Testbench for keypad_decoder: a behavioural keypad model checked against
// the DUT on every cycle, plus hand-computed expectations for key scenarios.
module tb_keypad_decoder;

`ifdef KEYPAD_DECODER_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  localparam int CONF = 4;
  localparam int REL  = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] rows = '0;
  logic [3:0] cols = '0;
  logic       change = 1'b0;
  logic       key_valid;
  logic [3:0] key;
  logic [3:0] digit_new;
  logic [3:0] digit_old;
  logic       err;

  int n_vec = 0;
  int n_bad = 0;

  keypad_decoder #(.CONFIRM_CYCLES(CONF), .RELEASE_CYCLES(REL)) dut (
    .clk(clk), .reset(reset), .rows(rows), .cols(cols), .change(change),
    .key_valid(key_valid), .key(key), .digit_new(digit_new),
    .digit_old(digit_old), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [3:0] keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                              4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC,
                              4'hE, 4'h0, 4'hF, 4'hD};
  bit         m_init = 0, m_pend = 0, m_held = 0;
  int         m_cnt = 0, m_zero = 0;
  logic [3:0] m_r = '0, m_c = '0;
  logic       e_kv = 0, e_err = 0;
  logic [3:0] e_key = '0, e_new = '0, e_old = '0;

  function automatic logic [3:0] key_of(input logic [3:0] r, input logic [3:0] c);
    int ri = 0, ci = 0;
    for (int i = 0; i < 4; i++) begin
      if (r[i]) ri = i;
      if (c[i]) ci = i;
    end
    return keymap[ri*4 + ci];
  endfunction

  always @(posedge clk) begin
    m_init = 1;
    if (!reset) begin
      m_pend = 0; m_held = 0; m_cnt = 0; m_zero = 0;
      e_kv = 0; e_err = 0; e_key = '0; e_new = '0; e_old = '0;
    end else begin
      e_kv = 0; e_err = 0;
      if (m_held) begin
        m_zero = (cols == 4'b0000) ? m_zero + 1 : 0;
        if (m_zero >= REL) m_held = 0;
      end else if (m_pend) begin
        if (rows == m_r && cols == m_c) begin
          m_cnt++;
          if (m_cnt >= CONF) begin
            e_old = e_new;
            e_new = key_of(m_r, m_c);
            e_key = e_new;
            e_kv = 1; m_pend = 0; m_held = 1; m_zero = 0;
          end
        end else begin
          m_pend = 0;
        end
      end else if (change) begin
        if ($countones(rows) == 1 && $countones(cols) == 1) begin
          m_pend = 1; m_cnt = 0; m_r = rows; m_c = cols;
        end else begin
          e_err = ERR_EN;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("m_key_valid", {3'b0, key_valid}, {3'b0, e_kv});
      chk("m_err",       {3'b0, err},       {3'b0, e_err});
      chk("m_key",       key,       e_key);
      chk("m_digit_new", digit_new, e_new);
      chk("m_digit_old", digit_old, e_old);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic press(input logic [3:0] r, input logic [3:0] c);
    @(negedge clk);
    rows = r; cols = c; change = 1'b1;
    @(negedge clk);
    change = 1'b0;
  endtask

  task automatic idle_n(input int n);
    rows = '0; cols = '0; change = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  int kvcnt;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_key_valid", {3'b0, key_valid}, 4'h0);
    chk("rst_key", key, 4'h0);
    chk("rst_digit_new", digit_new, 4'h0);
    chk("rst_digit_old", digit_old, 4'h0);
    chk("rst_err", {3'b0, err}, 4'h0);
    reset = 1'b1;
    idle_n(2);

    // Key 2: pulse exactly 5 cycles after the change cycle.
    press(4'b0001, 4'b0010);
    for (int i = 1; i <= 10; i++) begin
      chk("lat_key_valid", {3'b0, key_valid}, (i == 5) ? 4'h1 : 4'h0);
      if (i == 5) begin
        chk("k2_key", key, 4'h2);
        chk("k2_new", digit_new, 4'h2);
        chk("k2_old", digit_old, 4'h0);
      end
      @(negedge clk);
    end
    idle_n(10);

    // Key C held 50 cycles, with a stray change mid-hold.
    press(4'b0100, 4'b1000);
    kvcnt = 0;
    for (int i = 1; i <= 50; i++) begin
      kvcnt += int'(key_valid);
      change = (i == 20);
      @(negedge clk);
    end
    change = 1'b0;
    chk("kC_pulses", 4'(kvcnt), 4'h1);
    chk("kC_key", key, 4'hC);
    chk("kC_new", digit_new, 4'hC);
    chk("kC_old", digit_old, 4'h2);
    idle_n(10);

    // Broken press: cols drop on the second cycle.
    press(4'b0100, 4'b1000);
    cols = 4'b0000;
    kvcnt = 0;
    for (int i = 0; i < 10; i++) begin
      kvcnt += int'(key_valid);
      @(negedge clk);
    end
    chk("brk_pulses", 4'(kvcnt), 4'h0);
    chk("brk_key", key, 4'hC);
    chk("brk_old", digit_old, 4'h2);

    // Invalid patterns.
    press(4'b0001, 4'b0110);
    chk("inv_err_cols", {3'b0, err}, {3'b0, ERR_EN});
    idle_n(6);
    press(4'b0011, 4'b0001);
    chk("inv_err_rows", {3'b0, err}, {3'b0, ERR_EN});
    idle_n(6);
    press(4'b0000, 4'b0000);
    chk("inv_err_zero", {3'b0, err}, {3'b0, ERR_EN});
    idle_n(6);

    // Release counting: 7 zeros, one non-zero, 8 zeros; change on exit ignored.
    press(4'b0001, 4'b0001);
    repeat (7) @(negedge clk);
    cols = 4'b0000;
    repeat (7) @(negedge clk);
    cols = 4'b0001;
    @(negedge clk);
    cols = 4'b0000;
    repeat (7) @(negedge clk);
    rows = 4'b1000; change = 1'b1;
    @(negedge clk);
    change = 1'b0;
    chk("exit_err", {3'b0, err}, 4'h0);
    press(4'b1000, 4'b0010);
    repeat (4) @(negedge clk);
    chk("k0_valid", {3'b0, key_valid}, 4'h1);
    chk("k0_key", key, 4'h0);
    chk("k0_new", digit_new, 4'h0);
    chk("k0_old", digit_old, 4'h1);
    idle_n(10);

    // Reset during CONFIRM.
    press(4'b0010, 4'b0100);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", {3'b0, key_valid}, 4'h0);
    chk("mid_rst_key", key, 4'h0);
    chk("mid_rst_new", digit_new, 4'h0);
    chk("mid_rst_old", digit_old, 4'h0);
    reset = 1'b1;
    kvcnt = 0;
    for (int i = 0; i < 10; i++) begin
      kvcnt += int'(key_valid);
      @(negedge clk);
    end
    chk("mid_rst_pulses", 4'(kvcnt), 4'h0);
    idle_n(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/keypad_decoder.md
KEYPAD_DECODER -- requirements
Module: keypad_decoder

Interface
REQ-001 SHALL have parameter CONFIRM_CYCLES, default 4, meaning consecutive cycles a captured pattern must persist before acceptance (legal range 1..63).
REQ-002 SHALL have parameter RELEASE_CYCLES, default 8, meaning consecutive cycles with cols==0 required to declare release (legal range 1..63).
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port rows  input  4  row drive from scanner, active-high, bit i = row i.
REQ-006 SHALL have port cols  input  4  column sense from keypad, active-high, bit j = column j.
REQ-007 SHALL have port change  input  1  one-cycle strobe from scanner marking a new press on the driven row.
REQ-008 SHALL have port key_valid  output  1  one-cycle pulse when a key is accepted.
REQ-009 SHALL have port key  output  4  hex code of last accepted key.
REQ-010 SHALL have port digit_new  output  4  most recent accepted key.
REQ-011 SHALL have port digit_old  output  4  previously accepted key.
REQ-012 SHALL have port err  output  1  one-cycle pulse on invalid pattern at change.

Function
REQ-013 SHALL decode (row,col) to key: row0 = 1,2,3,A; row1 = 4,5,6,B; row2 = 7,8,9,C; row3 = E,0,F,D (cols 0..3).
REQ-014 SHALL implement states IDLE, CONFIRM, HOLD.
REQ-015 IDLE: on change with rows and cols both exactly one-hot, SHALL register rows/cols, clear confirm counter, go CONFIRM next cycle.
REQ-016 IDLE: on change with rows or cols not one-hot (zero or multi-bit), SHALL stay IDLE with no state update; err per REQ-027/028.
REQ-017 CONFIRM: each cycle rows==captured and cols==captured SHALL increment counter; any mismatch SHALL return to IDLE with no key_valid.
REQ-018 CONFIRM: in the cycle counter reaches CONFIRM_CYCLES, SHALL assert key_valid for exactly that one cycle, load key, shift digit_new->digit_old, load digit_new, go HOLD.
REQ-019 Acceptance latency: key_valid SHALL rise CONFIRM_CYCLES+1 cycles after the change cycle for an unbroken press.
REQ-020 HOLD: release counter SHALL increment each cycle cols==0, clear on any cycle cols!=0; on reaching RELEASE_CYCLES SHALL go IDLE.
REQ-021 change SHALL be ignored in CONFIRM and HOLD; held key SHALL never produce a second key_valid.
REQ-022 Counters SHALL saturate, never wrap; 6-bit width.
REQ-023 key, digit_new, digit_old SHALL hold value between acceptances.
REQ-024 change asserted in the same cycle HOLD exits to IDLE SHALL be ignored; next change in IDLE is honoured.

Reset
REQ-025 reset low at any clock edge, including mid-CONFIRM or HOLD, SHALL force IDLE, clear both counters and captured pattern, pending acceptance discarded.
REQ-026 Reset values: key_valid=0, err=0, key=0, digit_new=0, digit_old=0.

Configuration
REQ-027 With KEYPAD_DECODER_ERR_EN defined, err SHALL pulse one cycle, in the cycle after a change per REQ-016.
REQ-028 Without KEYPAD_DECODER_ERR_EN, err SHALL be tied 0; invalid patterns still silently rejected.

Verification
REQ-029 Reset then change with rows=0001, cols=0010 held 10 cycles -> key_valid pulse at cycle 5 after change, key=2, digit_new=2, digit_old=0.
REQ-030 Accept 2 then row2/col3 press -> key=C, digit_new=C, digit_old=2; hold 50 cycles -> single key_valid only.
REQ-031 change with rows=0100, cols=1000 then cols=0000 on cycle 2 -> no key_valid, state IDLE, digits unchanged.
REQ-032 change with cols=0110 -> err=1 one cycle (ERR_EN) / err=0 (no macro), no key_valid.
REQ-033 In HOLD, cols toggles 0 for 7 cycles then 1 for 1 cycle then 0 for 8 -> IDLE only after final 8th zero cycle; change at row3/col1 then yields key=0.
REQ-034 reset low during CONFIRM cycle 2 -> no key_valid, all outputs 0 next cycle.
